// File: rtl/rename_stage_pkg.sv
// ============================================================================
// Module  : ooo_pkg
// Brief   : Shared sizes and types for the register-rename slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ooo_pkg;

  localparam int ARCH_REGS  = 32;
  localparam int PHYS_REGS  = 64;
  localparam int PREG_W     = 6;
  localparam int AREG_W     = 5;
  localparam int FREE_DEPTH = 32;
  localparam int FPTR_W     = 5;
  localparam int CNT_W      = 6;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

endpackage

`default_nettype wire

// File: rtl/rename_stage_if.sv
// ============================================================================
// Module  : rename_stage_if
// Brief   : Decode/retire/writeback-facing signal bundle of the rename stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rename_stage_if;
  import ooo_pkg::*;

  logic                 In_Valid;
  areg_t                ArchA_IN;
  areg_t                ArchB_IN;
  areg_t                ArchDest_IN;
  logic                 RegWrite_IN;
  logic                 STALL_IN;
  logic                 Free_Valid_IN;
  preg_t                Free_Reg_IN;
  logic                 CDB_Valid_IN;
  preg_t                CDB_Reg_IN;
  preg_t                phy_regA_OUT;
  preg_t                phy_regB_OUT;
  preg_t                phy_regWrite_OUT;
  preg_t                phy_regOld_OUT;
  logic                 Valid_OUT;
  logic                 STALL_OUT;
  logic [PHYS_REGS-1:0] RegReady;

  modport master (
    output In_Valid, ArchA_IN, ArchB_IN, ArchDest_IN, RegWrite_IN, STALL_IN,
           Free_Valid_IN, Free_Reg_IN, CDB_Valid_IN, CDB_Reg_IN,
    input  phy_regA_OUT, phy_regB_OUT, phy_regWrite_OUT, phy_regOld_OUT,
           Valid_OUT, STALL_OUT, RegReady
  );

  modport slave (
    input  In_Valid, ArchA_IN, ArchB_IN, ArchDest_IN, RegWrite_IN, STALL_IN,
           Free_Valid_IN, Free_Reg_IN, CDB_Valid_IN, CDB_Reg_IN,
    output phy_regA_OUT, phy_regB_OUT, phy_regWrite_OUT, phy_regOld_OUT,
           Valid_OUT, STALL_OUT, RegReady
  );

endinterface

`default_nettype wire

// File: rtl/rename_free_list.sv
// ============================================================================
// Module  : rename_free_list
// Brief   : 32-entry circular FIFO of free physical registers (32..63 at reset).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rename_free_list
  import ooo_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  preg_t            push_reg,
  input  logic             pop,
  output preg_t            pop_reg,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  preg_t             mem [FREE_DEPTH];
  logic [FPTR_W-1:0] head;
  logic [FPTR_W-1:0] tail;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FREE_DEPTH));
  assign pop_reg = mem[head];

  // Physical 0 is the permanent home of r0 and must never circulate.
  assign do_push = push && (push_reg != '0) && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < FREE_DEPTH; i++) begin
        mem[i] <= preg_t'(FREE_DEPTH + i);
      end
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(FREE_DEPTH);
    end else begin
      if (do_push) begin
        mem[tail] <= push_reg;
        tail      <= tail + FPTR_W'(1);
      end
      if (do_pop) begin
        head <= head + FPTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rename_stage.sv
// ============================================================================
// Module  : rename_stage
// Brief   : RAT + free list + ready table; one-cycle register rename.
//           Build option RENAME_FREE_BYPASS_EN: retire-freed register feeds an
//           empty free list straight to the renaming instruction.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rename_stage
  import ooo_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  rename_stage_if.slave rn
);

  preg_t                rat [ARCH_REGS];
  logic [PHYS_REGS-1:0] ready;
  logic [PHYS_REGS-1:0] ready_nxt;

  preg_t                fl_head;
  logic                 fl_empty;
  logic                 fl_full;
  logic [CNT_W-1:0]     fl_count;
  logic                 fl_push;
  logic                 fl_pop;

  logic                 wants_alloc;
  logic                 bypass;
  logic                 stall;
  logic                 fire;
  logic                 alloc;
  preg_t                new_reg;

  preg_t                a_q;
  preg_t                b_q;
  preg_t                w_q;
  preg_t                o_q;
  logic                 valid_q;

  assign wants_alloc = rn.RegWrite_IN && (rn.ArchDest_IN != '0);

`ifdef RENAME_FREE_BYPASS_EN
  assign bypass = fl_empty && rn.Free_Valid_IN && (rn.Free_Reg_IN != '0);
`else
  assign bypass = 1'b0;
`endif

  assign stall   = rn.In_Valid && wants_alloc && fl_empty && !bypass;
  assign fire    = rn.In_Valid && !rn.STALL_IN && !stall;
  assign alloc   = fire && wants_alloc;
  assign new_reg = bypass ? rn.Free_Reg_IN : fl_head;

  // A bypassed register goes straight to the instruction and never enters the FIFO.
  assign fl_pop  = alloc && !bypass;
  assign fl_push = rn.Free_Valid_IN && !(alloc && bypass);

  rename_free_list u_fl (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (fl_push),
    .push_reg (rn.Free_Reg_IN),
    .pop      (fl_pop),
    .pop_reg  (fl_head),
    .empty    (fl_empty),
    .full     (fl_full),
    .count    (fl_count)
  );

  logic unused_fl;
  assign unused_fl = ^{fl_full, fl_count};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i] <= preg_t'(i);
      end
    end else if (alloc) begin
      rat[rn.ArchDest_IN] <= new_reg;
    end
  end

  // Allocation clear is applied after the CDB set so it wins on a collision.
  always_comb begin
    ready_nxt = ready;
    if (rn.CDB_Valid_IN) ready_nxt[rn.CDB_Reg_IN] = 1'b1;
    if (alloc)           ready_nxt[new_reg]       = 1'b0;
    ready_nxt[0] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) ready <= '1;
    else        ready <= ready_nxt;
  end

  // Sources read the pre-update RAT, so r5 <- r5+r5 sees the old mapping.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      o_q     <= '0;
      valid_q <= 1'b0;
    end else if (!rn.STALL_IN) begin
      valid_q <= fire;
      if (fire) begin
        a_q <= rat[rn.ArchA_IN];
        b_q <= rat[rn.ArchB_IN];
        w_q <= alloc ? new_reg : '0;
        o_q <= alloc ? rat[rn.ArchDest_IN] : '0;
      end
    end
  end

  assign rn.phy_regA_OUT     = a_q;
  assign rn.phy_regB_OUT     = b_q;
  assign rn.phy_regWrite_OUT = w_q;
  assign rn.phy_regOld_OUT   = o_q;
  assign rn.Valid_OUT        = valid_q;
  assign rn.STALL_OUT        = stall;
  assign rn.RegReady         = ready;

endmodule

`default_nettype wire

// File: tb/tb_rename_stage.sv
// ============================================================================
// Module  : tb_rename_stage
// Brief   : Directed + random self-checking bench against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rename_stage;
  import ooo_pkg::*;

`ifdef RENAME_FREE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  rename_stage_if rif ();
  rename_stage u_dut (.CLK(CLK), .RESET(RESET), .rn(rif));

  int total  = 0;
  int passed = 0;

  // Reference model: architectural map, FIFO of free registers, ready bits.
  int        rat [ARCH_REGS];
  int        fl [$];
  bit [63:0] rdy;
  int        ea, eb, ew, eo;
  bit        ev;
  int        pend [$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic mreset();
    for (int i = 0; i < ARCH_REGS; i++) rat[i] = i;
    fl.delete();
    for (int i = 32; i < 64; i++) fl.push_back(i);
    rdy = '1;
    ea = 0; eb = 0; ew = 0; eo = 0; ev = 1'b0;
    pend.delete();
  endtask

  task automatic drive(bit iv, int a, int b, int d, bit rw, bit sin = 1'b0,
                       bit fv = 1'b0, int fr = 0, bit cv = 1'b0, int cr = 0);
    rif.In_Valid      = iv;
    rif.ArchA_IN      = 5'(a);
    rif.ArchB_IN      = 5'(b);
    rif.ArchDest_IN   = 5'(d);
    rif.RegWrite_IN   = rw;
    rif.STALL_IN      = sin;
    rif.Free_Valid_IN = fv;
    rif.Free_Reg_IN   = 6'(fr);
    rif.CDB_Valid_IN  = cv;
    rif.CDB_Reg_IN    = 6'(cr);
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_valid"}, rif.Valid_OUT, 0);
    chk({tag, "_A"}, rif.phy_regA_OUT, 0);
    chk({tag, "_B"}, rif.phy_regB_OUT, 0);
    chk({tag, "_W"}, rif.phy_regWrite_OUT, 0);
    chk({tag, "_O"}, rif.phy_regOld_OUT, 0);
    chk({tag, "_ready"}, rif.RegReady, 64'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, "_count"}, u_dut.u_fl.count, 32);
  endtask

  // Called with inputs driven just after a rising edge.
  task automatic cycle();
    int a, b, d, fr, cr, newr;
    bit iv, rw, sin, fv, cv, want, empty, full, byp, stl, fire, alloc;
    iv = rif.In_Valid; a = int'(rif.ArchA_IN); b = int'(rif.ArchB_IN);
    d = int'(rif.ArchDest_IN); rw = rif.RegWrite_IN; sin = rif.STALL_IN;
    fv = rif.Free_Valid_IN; fr = int'(rif.Free_Reg_IN);
    cv = rif.CDB_Valid_IN; cr = int'(rif.CDB_Reg_IN);
    #1;
    want  = rw && (d != 0);
    empty = (fl.size() == 0);
    full  = (fl.size() == FREE_DEPTH);
    byp   = BYP && empty && fv && (fr != 0);
    stl   = iv && want && empty && !byp;
    chk("stall_out", rif.STALL_OUT, stl);
    fire  = iv && !sin && !stl;
    alloc = fire && want;
    newr  = byp ? fr : (alloc ? fl[0] : 0);
    if (!sin) begin
      if (fire) begin
        ea = rat[a]; eb = rat[b];
        ew = alloc ? newr : 0;
        eo = alloc ? rat[d] : 0;
        ev = 1'b1;
      end else begin
        ev = 1'b0;
      end
    end
    if (cv) rdy[cr] = 1'b1;
    if (alloc) rdy[newr] = 1'b0;
    rdy[0] = 1'b1;
    if (alloc) begin
      pend.push_back(rat[d]);
      rat[d] = newr;
      if (!byp) void'(fl.pop_front());
    end
    if (fv && !(alloc && byp) && (fr != 0) && !full) fl.push_back(fr);
    @(posedge CLK);
    #1;
    chk("valid", rif.Valid_OUT, ev);
    chk("phyA", rif.phy_regA_OUT, ea);
    chk("phyB", rif.phy_regB_OUT, eb);
    chk("phyW", rif.phy_regWrite_OUT, ew);
    chk("phyO", rif.phy_regOld_OUT, eo);
    chk("ready", rif.RegReady, rdy);
    chk("count", u_dut.u_fl.count, fl.size());
  endtask

  task automatic step(bit iv, int a, int b, int d, bit rw, bit sin = 1'b0,
                      bit fv = 1'b0, int fr = 0, bit cv = 1'b0, int cr = 0);
    drive(iv, a, b, d, rw, sin, fv, fr, cv, cr);
    cycle();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    mreset();
    check_reset_state("rst");
    RESET = 1'b1;
  endtask

  initial begin
    int cnt_before;
    drive(0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    do_reset();

    // r3 <- r1, r2
    step(1, 1, 2, 3, 1);
    chk("r3_A", rif.phy_regA_OUT, 1);
    chk("r3_B", rif.phy_regB_OUT, 2);
    chk("r3_W", rif.phy_regWrite_OUT, 32);
    chk("r3_O", rif.phy_regOld_OUT, 3);
    chk("r3_V", rif.Valid_OUT, 1);
    chk("r3_rdy32", rif.RegReady[32], 0);

    // r5 <- r5 + r5, twice
    do_reset();
    step(1, 5, 5, 5, 1);
    chk("r5a_A", rif.phy_regA_OUT, 5);
    chk("r5a_W", rif.phy_regWrite_OUT, 32);
    step(1, 5, 5, 5, 1);
    chk("r5b_A", rif.phy_regA_OUT, 32);
    chk("r5b_B", rif.phy_regB_OUT, 32);
    chk("r5b_W", rif.phy_regWrite_OUT, 33);
    chk("r5b_O", rif.phy_regOld_OUT, 32);

    // Exhaust the free list, then recover with a freed register
    do_reset();
    for (int k = 0; k < 32; k++) step(1, 0, 0, (k % 31) + 1, 1);
    drive(1, 1, 1, 2, 1, 0, 1, 7);
    #1;
`ifdef RENAME_FREE_BYPASS_EN
    chk("byp_stall", rif.STALL_OUT, 0);
    cycle();
    chk("byp_W", rif.phy_regWrite_OUT, 7);
    chk("byp_count", u_dut.u_fl.count, 0);
`else
    chk("empty_stall", rif.STALL_OUT, 1);
    cycle();
    chk("empty_valid", rif.Valid_OUT, 0);
    step(1, 0, 0, 4, 1);
    chk("freed7_W", rif.phy_regWrite_OUT, 7);
`endif

    // dest r0 / no write, then CDB wake-up
    do_reset();
    step(1, 1, 2, 6, 1);
    cnt_before = fl.size();
    step(1, 4, 6, 0, 1);
    chk("r0_W", rif.phy_regWrite_OUT, 0);
    chk("r0_O", rif.phy_regOld_OUT, 0);
    chk("r0_count", u_dut.u_fl.count, cnt_before);
    step(1, 4, 6, 9, 0);
    chk("nowr_W", rif.phy_regWrite_OUT, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32);
    chk("cdb32", rif.RegReady[32], 1);

    // Simultaneous push and pop at count=1
    do_reset();
    for (int k = 1; k < 32; k++) step(1, 0, 0, k, 1);
    chk("cnt1", u_dut.u_fl.count, 1);
    step(1, 0, 0, 5, 1, 0, 1, pend.pop_front());
    chk("pushpop_cnt", u_dut.u_fl.count, 1);

    // STALL_IN hold for three cycles, then release
    do_reset();
    step(1, 1, 2, 3, 1);
    for (int k = 0; k < 3; k++) step(1, 7, 8, 9, 1, 1);
    chk("hold_W", rif.phy_regWrite_OUT, 32);
    chk("hold_count", u_dut.u_fl.count, 31);
    step(1, 7, 8, 9, 1);
    chk("release_W", rif.phy_regWrite_OUT, 33);
    chk("release_O", rif.phy_regOld_OUT, 9);

    // Random traffic with a mid-stream reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit fv;
      int fr;
      if (n == 300) begin
        drive(1, 1, 2, 3, 1);
        #2;
        RESET = 1'b0;
        #1;
        check_reset_state("midrst");
        @(posedge CLK);
        #1;
        mreset();
        RESET = 1'b1;
        step(1, 1, 2, 3, 1);
        chk("post_rst_W", rif.phy_regWrite_OUT, 32);
        chk("post_rst_O", rif.phy_regOld_OUT, 3);
      end
      fv = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
      fr = fv ? pend.pop_front() : 0;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0,
           fv, fr, $urandom_range(0, 1) == 1, $urandom_range(0, 63));
    end
    while (pend.size() > 0) step(0, 0, 0, 0, 0, 0, 1, pend.pop_front());
    chk("drain_count", u_dut.u_fl.count, 32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rename_stage.md
RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 CLK  input  1  rising-edge clock for all state.
REQ-002 RESET  input  1  asynchronous, active-low reset.
REQ-003 In_Valid  input  1  a decoded instruction is presented this cycle.
REQ-004 ArchA_IN, ArchB_IN  input  5 each  architectural source registers.
REQ-005 ArchDest_IN  input  5  architectural destination register.
REQ-006 RegWrite_IN  input  1  instruction writes ArchDest_IN.
REQ-007 STALL_IN  input  1  issue queue full; hold all outputs and state.
REQ-008 Free_Valid_IN, Free_Reg_IN  input  1, 6  retire returns a physical register to the free list.
REQ-009 CDB_Valid_IN, CDB_Reg_IN  input  1, 6  writeback broadcast; the register becomes ready.
REQ-010 phy_regA_OUT, phy_regB_OUT, phy_regWrite_OUT, phy_regOld_OUT  output  6 each  renamed sources, new destination, and previous mapping of the destination (freed at retire).
REQ-011 Valid_OUT  output  1  registered outputs hold a renamed instruction.
REQ-012 STALL_OUT  output  1  combinational; rename is blocked this cycle.
REQ-013 RegReady  output  64  bit p = 1 when physical register p holds its value.

Function
REQ-014 Rename latency SHALL be 1 cycle; all outputs except STALL_OUT and RegReady SHALL be registered.
REQ-015 A rename SHALL fire when In_Valid && !STALL_IN && !STALL_OUT.
REQ-016 On fire, sources SHALL read the RAT before the same-cycle destination update, so r5 <- r5+r5 uses the old mapping.
REQ-017 On fire with RegWrite_IN=1 and ArchDest_IN!=0:
- pop the free-list head into phy_regWrite_OUT;
- place the old RAT entry into phy_regOld_OUT;
- write the RAT;
- clear RegReady of the new register.
REQ-018 ArchDest_IN=0 or RegWrite_IN=0 SHALL allocate nothing; phy_regWrite_OUT and phy_regOld_OUT SHALL be 0.
REQ-019 Architectural r0 SHALL always map to physical 0, and RegReady[0] SHALL stay 1.
REQ-020 STALL_OUT SHALL be asserted when In_Valid && RegWrite_IN && ArchDest_IN!=0 && the free list is empty.
REQ-021 If In_Valid && STALL_OUT && !STALL_IN, Valid_OUT SHALL be 0 next cycle.
REQ-022 If STALL_IN is asserted, every registered output SHALL hold its value.
REQ-023 If neither fires nor STALL_IN holds, Valid_OUT SHALL be 0.
REQ-024 The free list SHALL be a 32-entry circular FIFO with 5-bit head/tail pointers wrapping 31->0 and a 6-bit count (0..32).
REQ-025 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-026 A push when count=32 SHALL be ignored.
REQ-027 A push of register 0 SHALL be ignored.
REQ-028 CDB_Valid_IN SHALL set RegReady[CDB_Reg_IN] next cycle.
REQ-029 A CDB set and a rename clear of the same register in one cycle is illegal, since an allocated register is never in flight; if it occurs, the clear SHALL win.

Reset
REQ-030 While RESET=0:
- RAT entry i SHALL equal i;
- the free list SHALL hold physical 32..63 in order, with head=0, tail=0, count=32;
- RegReady SHALL be all ones;
- all registered outputs SHALL be 0.
REQ-031 Reset asserted mid-rename SHALL discard the in-flight rename with no partial RAT or free-list update.

Configuration
REQ-032 With RENAME_FREE_BYPASS_EN defined, when count=0 and Free_Valid_IN=1:
- STALL_OUT SHALL deassert;
- Free_Reg_IN SHALL be allocated directly to the renaming instruction;
- the count SHALL stay 0.
REQ-033 Without RENAME_FREE_BYPASS_EN, an empty free list SHALL stall for that cycle regardless of Free_Valid_IN.

Structure
REQ-034 Package ooo_pkg SHALL hold:
- ARCH_REGS=32, PHYS_REGS=64, PREG_W=6, FREE_DEPTH=32;
- the preg_t typedef.
REQ-035 The free list SHALL be the sub-module rename_free_list, providing push, pop, empty, full, and count.

Verification
REQ-036 Reset, then rename r3<-r1,r2 -> next cycle phy A=1, B=2, Write=32, Old=3, Valid_OUT=1, RegReady[32]=0.
REQ-037 Rename r5<-r5,r5 twice -> first: A=B=5, Write=32; second: A=B=32, Write=33, Old=32.
REQ-038 Make 32 allocating renames with no frees, then a 33rd -> STALL_OUT=1 and Valid_OUT=0. Free reg 7 -> the next rename gets Write=7. With the bypass macro, freeing 7 in the stalling cycle -> Write=7 immediately.
REQ-039 Rename with dest r0 -> Write=0, Old=0, free count unchanged. CDB broadcast of 32 after allocation -> RegReady[32]=1 next cycle.
REQ-040 Push and pop in the same cycle with count=1 -> count stays 1. Wrap-around: a 40-rename/40-free cycle returns all registers with no loss or duplication.
REQ-041 Assert STALL_IN for 3 cycles with In_Valid=1 -> outputs and free count frozen, then one rename on release. RESET pulse mid-stream -> state exactly as REQ-030.
